// File: rtl/pio_pkg.sv
// Shared register offsets and sizing helpers for the edge-capturing parallel input port.
package pio_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 3;

  localparam logic [AddrW-1:0] ADDR_DATA = 3'd0;
  localparam logic [AddrW-1:0] ADDR_RISE = 3'd1;
  localparam logic [AddrW-1:0] ADDR_FALL = 3'd2;
  localparam logic [AddrW-1:0] ADDR_MASK = 3'd3;
  localparam logic [AddrW-1:0] ADDR_EDGE = 3'd4;

  // Counter width for a debounce window; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input bit: two-flop synchroniser followed by a stable-count debounce filter.
module pio_debounce
  import pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic stable_o
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign stable_o = sync2_q;
  end else begin : g_filter
    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
        if (cnt_q == CntLast) begin
          stable_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign stable_o = stable_q;
  end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM parallel input port with debounced inputs, edge capture and masked level IRQ.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_RESET      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AddrW-1:0] address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [DataW-1:0] writedata,
  output logic [DataW-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic             EdgeRstBit = (EDGE_RESET & 32'd1) != 0;
  localparam logic [WIDTH-1:0] RiseRst    = {WIDTH{EdgeRstBit}};

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             irq_q, irq_d;
  logic [DataW-1:0] rd_q, rd_d;
  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk),
      .rst_i   (reset),
      .in_i    (in_port[i]),
      .stable_o(stable[i])
    );
  end

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign clr          = (wr && (address == ADDR_EDGE)) ? wdata : '0;

  always_comb begin
    edge_d = (stable & ~prev_q & rise_en_q) | (~stable & prev_q & fall_en_q);
    // A fresh edge wins over a simultaneous clear of the same bit.
    cap_d  = (cap_q & ~clr) | edge_q;
    irq_d  = |(cap_q & mask_q);
  end

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    if (wr) begin
      case (address)
        ADDR_RISE: rise_en_d = wdata;
        ADDR_FALL: fall_en_d = wdata;
        ADDR_MASK: mask_d    = wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d[WIDTH-1:0] = stable;
      ADDR_RISE: rd_d[WIDTH-1:0] = rise_en_q;
      ADDR_FALL: rd_d[WIDTH-1:0] = fall_en_q;
      ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_d[WIDTH-1:0] = cap_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      edge_q    <= '0;
      rise_en_q <= RiseRst;
      fall_en_q <= '0;
      mask_q    <= '0;
      cap_q     <= '0;
      irq_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      prev_q    <= stable;
      edge_q    <= edge_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      irq_q     <= irq_d;
      rd_q      <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: two instances (filtered and bypassed) against a cycle reference model.
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd4, rd0;
  logic        irq4, irq0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_RESET(1)) dut4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd4), .in_port(in_port), .irq(irq4)
  );

  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_RESET(1)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0)
  );

  // Reference state: what the port's visible behaviour depends on, one record per instance.
  typedef struct packed {
    logic [3:0]      s1, s2;   // two samples of in_port delay
    logic [3:0]      stb;      // accepted level
    logic [3:0][7:0] run;      // consecutive samples the synced level has disagreed
    logic [3:0]      prev;
    logic [3:0]      ev;       // edge seen last cycle, lands in capture this cycle
    logic [3:0]      cap, ren, fen, mask;
    logic            irq;
    logic [31:0]     rd;
  } model_t;

  model_t m4, m0;

  function automatic model_t mreset();
    model_t r;
    r     = '0;
    r.ren = 4'hF;
    return r;
  endfunction

  function automatic model_t mstep(input model_t m, input int unsigned n, input logic [3:0] inp,
                                   input logic cs, input logic wn, input logic [2:0] a,
                                   input logic [31:0] wd);
    model_t     r;
    logic [3:0] lvl, rise, fall;
    logic       wr;
    r    = m;
    lvl  = (n == 0) ? m.s2 : m.stb;
    rise = lvl & ~m.prev & m.ren;
    fall = ~lvl & m.prev & m.fen;
    wr   = cs && !wn;
    r.s1 = inp;
    r.s2 = m.s1;
    for (int i = 0; i < 4; i++) begin
      if (n != 0 && m.s2[i] != m.stb[i]) begin
        if (int'(m.run[i]) + 1 >= int'(n)) begin
          r.stb[i] = m.s2[i];
          r.run[i] = 8'd0;
        end else begin
          r.run[i] = m.run[i] + 8'd1;
        end
      end else begin
        r.run[i] = 8'd0;
      end
    end
    r.prev = lvl;
    r.ev   = rise | fall;
    r.cap  = (m.cap & ~((wr && a == 3'd4) ? wd[3:0] : 4'h0)) | m.ev;
    r.irq  = |(m.cap & m.mask);
    case (a)
      3'd0:    r.rd = {28'd0, lvl};
      3'd1:    r.rd = {28'd0, m.ren};
      3'd2:    r.rd = {28'd0, m.fen};
      3'd3:    r.rd = {28'd0, m.mask};
      3'd4:    r.rd = {28'd0, m.cap};
      default: r.rd = 32'd0;
    endcase
    if (wr && a == 3'd1) r.ren  = wd[3:0];
    if (wr && a == 3'd2) r.fen  = wd[3:0];
    if (wr && a == 3'd3) r.mask = wd[3:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m4 = mreset();
      m0 = mreset();
    end else begin
      m4 = mstep(m4, 4, in_port, chipselect, write_n, address, writedata);
      m0 = mstep(m0, 0, in_port, chipselect, write_n, address, writedata);
    end
    @(negedge clk);
    check("model_rd4", rd4, m4.rd);
    check("model_irq4", {31'd0, irq4}, {31'd0, m4.irq});
    check("model_rd0", rd0, m0.rd);
    check("model_irq0", {31'd0, irq0}, {31'd0, m0.irq});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read4(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    tick();
    check(name, rd4, exp);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    m4 = mreset();
    m0 = mreset();
    #1;
    check("rst_rd4", rd4, 32'd0);
    check("rst_irq4", {31'd0, irq4}, 32'd0);
    check("rst_rd0", rd0, 32'd0);
    check("rst_irq0", {31'd0, irq0}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{3'd1, 32'h0000_0005, 32'h5};
    vt[1]  = '{3'd2, 32'h0000_000A, 32'hA};
    vt[2]  = '{3'd3, 32'hFFFF_FFF6, 32'h6};
    vt[3]  = '{3'd0, 32'h0000_000F, 32'h0};
    vt[4]  = '{3'd5, 32'h0000_000F, 32'h0};
    vt[5]  = '{3'd6, 32'h0000_000F, 32'h0};
    vt[6]  = '{3'd7, 32'hFFFF_FFFF, 32'h0};
    vt[7]  = '{3'd4, 32'h0000_000F, 32'h0};
    vt[8]  = '{3'd1, 32'h0000_000F, 32'hF};
    vt[9]  = '{3'd2, 32'h0000_0000, 32'h0};
    vt[10] = '{3'd3, 32'h0000_0000, 32'h0};

    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; in_port = 4'h0;
    m4 = mreset();
    m0 = mreset();
    #1;
    check("init_rd", rd4, 32'd0);
    check("init_irq", {31'd0, irq4}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    read4("rst_rise_en", 3'd1, 32'hF);
    read4("rst_fall_en", 3'd2, 32'h0);
    read4("rst_mask", 3'd3, 32'h0);
    read4("rst_edge", 3'd4, 32'h0);

    foreach (vt[i]) begin
      bus_write(vt[i].a, vt[i].wd);
      read4($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
    end

    // Rising edge on bit 0 held: capture lands eight edges after the change.
    address = 3'd4; in_port = 4'h1;
    ticks(8);
    check("a_edge_early", rd4, 32'h0);
    tick();
    check("a_edge", rd4, 32'h1);
    ticks(2);
    read4("a_data", 3'd0, 32'h1);
    in_port = 4'h0;
    ticks(10);
    bus_write(3'd4, 32'hF);

    // Three-cycle glitch on bit 1 must be filtered out.
    address = 3'd4; in_port = 4'h2;
    ticks(3);
    in_port = 4'h0;
    ticks(10);
    check("b_edge", rd4, 32'h0);
    check("b_irq", {31'd0, irq4}, 32'd0);
    read4("b_data", 3'd0, 32'h0);
    bus_write(3'd4, 32'hF);

    // Falling edge on bit 2 with interrupt enabled, then W1C.
    bus_write(3'd2, 32'h4);
    in_port = 4'h4;
    ticks(10);
    bus_write(3'd4, 32'hF);
    bus_write(3'd3, 32'h4);
    address = 3'd4;
    ticks(2);
    check("c_irq_idle", {31'd0, irq4}, 32'd0);
    in_port = 4'h0;
    ticks(8);
    check("c_irq_early", {31'd0, irq4}, 32'd0);
    tick();
    check("c_edge", rd4, 32'h4);
    check("c_irq", {31'd0, irq4}, 32'd1);
    bus_write(3'd4, 32'h4);
    tick();
    check("c_clr_edge", rd4, 32'h0);
    check("c_clr_irq", {31'd0, irq4}, 32'd0);

    // New edge on bit 3 in the same cycle as its clear.
    in_port = 4'h8;
    ticks(7);
    address = 3'd4; writedata = 32'h8; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    tick();
    check("d_set_wins", rd4, 32'h8);

    // Fill edge capture, then reset in the middle of a pending change.
    bus_write(3'd2, 32'hF);
    bus_write(3'd3, 32'hF);
    in_port = 4'h0;
    ticks(12);
    bus_write(3'd4, 32'hF);
    in_port = 4'hF;
    ticks(12);
    read4("e_edge_full", 3'd4, 32'hF);
    check("e_irq_set", {31'd0, irq4}, 32'd1);
    in_port = 4'h0;
    ticks(3);
    async_reset();
    in_port = 4'h3;
    ticks(2);
    reset = 1'b0;
    read4("e_rise_en", 3'd1, 32'hF);
    read4("e_fall_en", 3'd2, 32'h0);
    read4("e_mask", 3'd3, 32'h0);
    read4("e_edge_clr", 3'd4, 32'h0);
    ticks(8);
    check("e_first_rise", rd4, 32'h3);

    // Bypassed filter: a one-cycle pulse is captured four edges later.
    in_port = 4'h0;
    ticks(12);
    bus_write(3'd4, 32'hF);
    bus_write(3'd2, 32'h0);
    address = 3'd4;
    tick();
    in_port = 4'h1;
    tick();
    in_port = 4'h0;
    ticks(3);
    check("f_pulse_early", rd0, 32'h0);
    tick();
    check("f_pulse", rd0, 32'h1);

    // Random traffic and inputs against the model.
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        async_reset();
        tick();
        reset = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) in_port = 4'($urandom);
      else if ($urandom_range(0, 15) == 0) in_port = in_port ^ (4'h1 << $urandom_range(0, 3));
      address    = 3'($urandom);
      chipselect = ($urandom_range(0, 2) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = $urandom;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
